flicky_chiprom_arb: RTL
=======================

Name: flicky_chiprom_arb

Overview:
- Arbitrates the single sprite/tile chip-ROM read port between two requesters: the sprite line renderer and the background tile fetcher.
- Runs in the VCLKx4 domain.
- Gives the sprite renderer strict priority during active display and round-robin access during H-blank.
- Holds a one-entry last-address cache per requester, so repeated reads of the same byte cost no ROM access. Timed-out ROM reads are reported through a sticky error flag.

Parameters:
AW, 15, ROM byte address width
DW, 8, ROM data width
TIMEOUT, 15, max cycles rom_req may stay high without rom_ack (range 1..255)
CACHE_EN, 1, 1 = last-address cache enabled; 0 = every request goes to ROM

Ports:
VCLKx4  in  1  clock
RESET  in  1  synchronous active-high reset
HB  in  1  H-blank flag: 0 = sprite priority, 1 = round-robin
spr_req  in  1  sprite read request, level, held until spr_ack
spr_ad  in  AW  sprite read address
spr_ack  out  1  one-cycle pulse, spr_dt valid
spr_dt  out  DW  sprite read data, held until next spr_ack
bg_req  in  1  background read request, level
bg_ad  in  AW  background read address
bg_ack  out  1  one-cycle pulse, bg_dt valid
bg_dt  out  DW  background read data, held until next bg_ack
rom_req  out  1  ROM read strobe, held until rom_ack or timeout
rom_ad  out  AW  ROM address, stable while rom_req=1
rom_ack  in  1  ROM data valid (single cycle)
rom_dt  in  DW  ROM data
err  out  1  sticky timeout flag, cleared only by RESET

Behaviour:
- Clock and reset: one clock, VCLKx4, positive edge. Reset is synchronous and active-high on RESET.
- Reset values: all outputs 0; FSM to IDLE; both cache valid bits 0; round-robin pointer to sprite; timeout counter 0.
- Reset mid-transaction aborts it. No ack is issued. A rom_ack arriving after reset is ignored.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, winner selection:
  - HB=0: spr wins if spr_req=1, else bg.
  - HB=1: round-robin. The pointer toggles to the other requester after each grant. If only one requester is asserting, it wins.
  - The winner's address is latched into the granted slot.
- IDLE, cache hit (CACHE_EN=1, slot valid, address equals slot tag): go to DONE. rom_req stays 0.
- IDLE, cache miss: go to ISSUE. rom_req=1 and rom_ad=latched address, both registered in the next cycle.
- ISSUE:
  - rom_req is held high. The timeout counter increments each cycle.
  - rom_ack=1: capture rom_dt into the slot data and tag, set valid, drop rom_req, go to DONE.
  - Counter reaches TIMEOUT without rom_ack: drop rom_req, set slot data to 0 (transparent pixel), set err=1, leave the cache untouched, go to DONE.
  - rom_ack and timeout in the same cycle: rom_ack wins.
- DONE: the granted requester's ack pulses one cycle with dt = slot data. Next state is IDLE. No grant is made in DONE.
- Latency, hit: request seen in cycle 0, ack in cycle 1.
- Latency, miss: rom_req high from cycle 1; rom_ack at cycle n gives requester ack at cycle n+1.
- Back-to-back: minimum request spacing is 2 cycles. A requester may present its next address from the cycle after ack.
- req dropped while granted: the transaction still completes and ack is still pulsed. The requester must tolerate it.
- rom_ack while in IDLE or DONE is ignored.
- Caches hold only the last address per requester. ROM contents are static, so there is no flush.
- Address compare is a full AW-bit compare. The counter width is ceil(log2(TIMEOUT+1)).

Decomposition:
- Shared package flicky_pkg: state enum (IDLE/ISSUE/DONE), requester ID constants (REQ_SPR=0, REQ_BG=1), default AW/DW.
- One sub-module, flicky_arb_slot, instantiated twice (one per requester). It contains:
  - address latch, tag, valid bit, data register;
  - hit compare;
  - ack/dt output registers.
- The top level holds the FSM, the round-robin pointer, the timeout counter and the ROM port.

Test Plan:
- Priority: HB=0, spr_req and bg_req rise in the same cycle (spr_ad=0x0100, bg_ad=0x2000), rom_ack 3 cycles after rom_req -> rom_ad=0x0100 first; spr_ack with spr_dt=rom_dt; bg is served only after spr_ack.
- Round-robin: HB=1, both requesting continuously with distinct addresses, CACHE_EN=0 -> grants alternate spr, bg, spr, bg over 4 transactions.
- Cache: spr reads 0x1234 (miss, data 0xA5), then reads 0x1234 again -> second spr_ack 1 cycle after request, rom_req stays 0, spr_dt=0xA5.
- Timeout: TIMEOUT=15, rom_ack never asserted -> rom_req drops after 15 cycles; bg_ack with bg_dt=0x00; err=1 and stays 1; the same address misses again on retry.
- rom_ack coinciding with the timeout cycle -> data accepted, err stays 0.
- Reset during ISSUE -> no ack; rom_req=0 next cycle; a late rom_ack is ignored; caches invalid (the next read of a previously cached address issues rom_req).

Source files
------------

// File: rtl/flicky_pkg.sv
// Shared types and constants for the chip-ROM arbiter.
package flicky_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Requester IDs, also used as the round-robin pointer and grant encoding.
    localparam logic REQ_SPR = 1'b0;
    localparam logic REQ_BG  = 1'b1;

    localparam int unsigned FLICKY_AW = 15;
    localparam int unsigned FLICKY_DW = 8;

endpackage

// File: rtl/flicky_arb_slot.sv
// Per-requester slot: address latch, one-entry last-address cache and ack/dt output registers.
module flicky_arb_slot
    import flicky_pkg::*;
#(
    parameter int unsigned AW       = FLICKY_AW,
    parameter int unsigned DW       = FLICKY_DW,
    parameter int unsigned CACHE_EN = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] ad_i,
    input  logic          lat_i,       // slot granted this cycle
    input  logic          hit_done_i,  // granted and cache hit
    input  logic          fill_i,      // ROM data returned for this slot
    input  logic          tmo_i,       // ROM read for this slot timed out
    input  logic [DW-1:0] fill_dt_i,
    output logic          hit_o,
    output logic          ack_o,
    output logic [DW-1:0] dt_o
);

    logic [AW-1:0] adr_q;
    logic [AW-1:0] tag_q;
    logic          valid_q;
    logic [DW-1:0] cache_q;
    logic          ack_q;
    logic [DW-1:0] dt_q;

    // Full-width compare of the presented address against the cached tag.
    assign hit_o = (CACHE_EN != 0) && valid_q && (ad_i == tag_q);

    // Address latch, cache fill and ack/data output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            cache_q <= '0;
            ack_q   <= 1'b0;
            dt_q    <= '0;
        end else begin
            ack_q <= hit_done_i | fill_i | tmo_i;
            if (lat_i) begin
                adr_q <= ad_i;
            end
            if (hit_done_i) begin
                dt_q <= cache_q;
            end
            if (fill_i) begin
                dt_q    <= fill_dt_i;
                cache_q <= fill_dt_i;
                tag_q   <= adr_q;
                valid_q <= 1'b1;
            end
            // Timed-out read returns a transparent pixel; cache left as it was.
            if (tmo_i) begin
                dt_q <= '0;
            end
        end
    end

    assign ack_o = ack_q;
    assign dt_o  = dt_q;

endmodule

// File: rtl/flicky_chiprom_arb.sv
// Two-requester chip-ROM read arbiter: sprite priority in active display, round-robin in H-blank.
module flicky_chiprom_arb
    import flicky_pkg::*;
#(
    parameter int unsigned AW       = FLICKY_AW,
    parameter int unsigned DW       = FLICKY_DW,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CACHE_EN = 1
) (
    input  logic          VCLKx4,
    input  logic          RESET,
    input  logic          HB,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_ad,
    output logic          spr_ack,
    output logic [DW-1:0] spr_dt,
    input  logic          bg_req,
    input  logic [AW-1:0] bg_ad,
    output logic          bg_ack,
    output logic [DW-1:0] bg_dt,
    output logic          rom_req,
    output logic [AW-1:0] rom_ad,
    input  logic          rom_ack,
    input  logic [DW-1:0] rom_dt,
    output logic          err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e        state_q;
    logic          rr_q;
    logic          gnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic          rom_req_q;
    logic [AW-1:0] rom_ad_q;
    logic          err_q;

    logic          any_req;
    logic          win;
    logic [AW-1:0] win_ad;
    logic          win_hit;
    logic          spr_hit;
    logic          bg_hit;
    logic          grant;
    logic          fill;
    logic          tmo;

    // Winner selection for a grant made in IDLE.
    always_comb begin
        any_req = spr_req | bg_req;
        if (spr_req && bg_req) begin
            win = HB ? rr_q : REQ_SPR;
        end else begin
            win = spr_req ? REQ_SPR : REQ_BG;
        end
        win_ad  = (win == REQ_BG) ? bg_ad : spr_ad;
        win_hit = (win == REQ_BG) ? bg_hit : spr_hit;
    end

    assign grant = (state_q == IDLE) && any_req;
    assign fill  = (state_q == ISSUE) && rom_ack;
    // rom_ack has precedence over a timeout in the same cycle.
    assign tmo   = (state_q == ISSUE) && !rom_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    flicky_arb_slot #(
        .AW      (AW),
        .DW      (DW),
        .CACHE_EN(CACHE_EN)
    ) u_slot_spr (
        .clk_i     (VCLKx4),
        .rst_i     (RESET),
        .ad_i      (spr_ad),
        .lat_i     (grant && (win == REQ_SPR)),
        .hit_done_i(grant && (win == REQ_SPR) && win_hit),
        .fill_i    (fill && (gnt_q == REQ_SPR)),
        .tmo_i     (tmo && (gnt_q == REQ_SPR)),
        .fill_dt_i (rom_dt),
        .hit_o     (spr_hit),
        .ack_o     (spr_ack),
        .dt_o      (spr_dt)
    );

    flicky_arb_slot #(
        .AW      (AW),
        .DW      (DW),
        .CACHE_EN(CACHE_EN)
    ) u_slot_bg (
        .clk_i     (VCLKx4),
        .rst_i     (RESET),
        .ad_i      (bg_ad),
        .lat_i     (grant && (win == REQ_BG)),
        .hit_done_i(grant && (win == REQ_BG) && win_hit),
        .fill_i    (fill && (gnt_q == REQ_BG)),
        .tmo_i     (tmo && (gnt_q == REQ_BG)),
        .fill_dt_i (rom_dt),
        .hit_o     (bg_hit),
        .ack_o     (bg_ack),
        .dt_o      (bg_dt)
    );

    // Arbitration FSM with round-robin pointer, timeout counter and registered ROM port.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state_q   <= IDLE;
            rr_q      <= REQ_SPR;
            gnt_q     <= REQ_SPR;
            cnt_q     <= '0;
            rom_req_q <= 1'b0;
            rom_ad_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q <= win;
                        rr_q  <= ~win;
                        cnt_q <= '0;
                        if (win_hit) begin
                            state_q <= DONE;
                        end else begin
                            state_q   <= ISSUE;
                            rom_req_q <= 1'b1;
                            rom_ad_q  <= win_ad;
                        end
                    end
                end
                ISSUE: begin
                    if (rom_ack) begin
                        rom_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end else if (tmo) begin
                        rom_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_req = rom_req_q;
    assign rom_ad  = rom_ad_q;
    assign err     = err_q;

endmodule
